multi_tone_sfx: RTL and testbench

N-channel beep/effect generator for the game video pipeline. A free-running tone divider is clocked by the video line strobe, and note durations are timed in frames. Each channel has:
- a triggerable note, with a run-time selected pitch (a divider tap) and a length in frames;
- optional auto-repeat while its trigger is held.

Channels are combined into a 1-bit speaker output (XOR or priority mode) and a multi-bit level output for an external DAC. Fully synchronous to clk; line_pulse and frame_pulse are single-clk-wide strobes from the video timing block.

---
 rtl/sfx_pkg.sv | 26 ++
 rtl/sfx_channel.sv | 120 ++++++++++++
 rtl/multi_tone_sfx.sv | 117 +++++++++++
 tb/tb_multi_tone_sfx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// ---------------------------------------------------------------------------
// sfx_pkg
// Shared constants for the multi-tone sound effect generator.
//   MIX_XOR / MIX_PRIO : values of the mode input
//   ST_IDLE / ST_PLAY  : per-channel state encoding
//   clog2()            : parameter sanity checks (tap and level widths)
// ---------------------------------------------------------------------------
package sfx_pkg;

    localparam logic MIX_XOR  = 1'b0;
    localparam logic MIX_PRIO = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : sfx_pkg

// File: rtl/sfx_channel.sv
// ---------------------------------------------------------------------------
// sfx_channel
// One note channel: IDLE/PLAY state, frame counter, latched tap and length.
// Ports:
//   clk, nRst      : clock, asynchronous active-low reset
//   frame_pulse_i  : one-clk strobe per frame, advances the frame counter
//   trig_i         : level-sensitive trigger
//   tone_sel_i     : requested divider tap (latched on trigger)
//   length_i       : requested length in frames (latched on trigger)
//   divider_i      : shared free-running tone divider
//   active_o       : channel is playing (registered state; this is the FSM
//                    state bit, ST_PLAY == 1)
//   tone_o         : divider bit at the latched tap
//   wave_o         : active_o & tone_o
//
// Handshake: none; trig_i is sampled every clk, there is no ready path.
// ---------------------------------------------------------------------------
module sfx_channel
    import sfx_pkg::*;
#(
    parameter int DIV_W = 6,
    parameter int TAP_W = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             frame_pulse_i,
    input  logic             trig_i,
    input  logic [TAP_W-1:0] tone_sel_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic [DIV_W-1:0] divider_i,
    output logic             active_o,
    output logic             tone_o,
    output logic             wave_o
);

    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(DIV_W - 1);

    logic [0:0]       state_q, state_d;
    logic [LEN_W-1:0] fcnt_q,  fcnt_d;
    logic [TAP_W-1:0] tap_q,   tap_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [TAP_W-1:0] tap_clamped;

    // Clamp at latch time so the stored tap is always a legal divider index.
    always_comb begin
        tap_clamped = tone_sel_i;
        if (tone_sel_i > TAP_MAX) begin
            tap_clamped = TAP_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        tap_d   = tap_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                // Starts even on a frame_pulse cycle; the pulse is not counted.
                if (trig_i) begin
                    state_d = ST_PLAY;
                    fcnt_d  = '0;
                    tap_d   = tap_clamped;
                    len_d   = length_i;
                end
            end
            default: begin
                if (frame_pulse_i) begin
                    if (fcnt_q == len_q) begin
                        fcnt_d = '0;
                        if (trig_i) begin
                            // Auto-repeat while trigger is held.
                            tap_d = tap_clamped;
                            len_d = length_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Mid-note frame: trigger ignored this cycle.
                        fcnt_d = fcnt_q + LEN_W'(1);
                    end
                end else if (trig_i) begin
                    // Retrigger restarts the note with fresh settings.
                    fcnt_d = '0;
                    tap_d  = tap_clamped;
                    len_d  = length_i;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            tap_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tap_q   <= tap_d;
            len_q   <= len_d;
        end
    end

    // Explicit mux keeps the index width independent of DIV_W.
    always_comb begin
        tone_o = 1'b0;
        for (int k = 0; k < DIV_W; k++) begin
            if (tap_q == TAP_W'(k)) begin
                tone_o = divider_i[k];
            end
        end
    end

    assign active_o = (state_q == ST_PLAY);
    assign wave_o   = active_o & tone_o;

endmodule : sfx_channel

// File: rtl/multi_tone_sfx.sv
// ---------------------------------------------------------------------------
// multi_tone_sfx
// N-channel beep/effect generator. A line-strobed tone divider feeds
// NUM_CH note channels; their waves are mixed into a speaker bit and a
// level count for an external DAC.
// Ports:
//   clk, nRst    : clock, asynchronous active-low reset
//   line_pulse   : one-clk strobe per video line, advances the divider
//   frame_pulse  : one-clk strobe per frame, advances note timers
//   trig         : per-channel trigger (level-sensitive)
//   tone_sel     : per-channel tap, channel i at [i*TAP_W +: TAP_W]
//   length       : per-channel length, channel i at [i*LEN_W +: LEN_W]
//   mode         : 0 = XOR mix, 1 = priority (lowest active channel wins)
//   sound        : registered speaker bit
//   level        : registered count of channels whose wave is high
//   active       : per-channel playing flags (channel state)
// Outputs sound/level are registered from the current channel state, so
// they lag the state by one clk.
// ---------------------------------------------------------------------------
module multi_tone_sfx
    import sfx_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 6,
    parameter int TAP_W  = 3,
    parameter int LEN_W  = 4,
    parameter int LVL_W  = 3
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    line_pulse,
    input  logic                    frame_pulse,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH*TAP_W-1:0] tone_sel,
    input  logic [NUM_CH*LEN_W-1:0] length,
    input  logic                    mode,
    output logic                    sound,
    output logic [LVL_W-1:0]        level,
    output logic [NUM_CH-1:0]       active
);

    if (TAP_W < clog2(DIV_W)) begin : g_bad_tap_w
        $error("TAP_W too narrow to address all divider taps");
    end
    if (LVL_W < clog2(NUM_CH + 1)) begin : g_bad_lvl_w
        $error("LVL_W too narrow to count all channels");
    end

    logic [DIV_W-1:0]  divider_q, divider_d;
    logic              sound_q,   sound_d;
    logic [LVL_W-1:0]  level_q,   level_d;
    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] ch_tone;
    logic [NUM_CH-1:0] ch_wave;
    logic              xor_bit;
    logic              prio_bit;

    // Free-running divider, wraps naturally at 2^DIV_W.
    always_comb begin
        divider_d = divider_q;
        if (line_pulse) begin
            divider_d = divider_q + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sfx_channel #(
            .DIV_W (DIV_W),
            .TAP_W (TAP_W),
            .LEN_W (LEN_W)
        ) u_ch (
            .clk           (clk),
            .nRst          (nRst),
            .frame_pulse_i (frame_pulse),
            .trig_i        (trig[i]),
            .tone_sel_i    (tone_sel[i*TAP_W +: TAP_W]),
            .length_i      (length[i*LEN_W +: LEN_W]),
            .divider_i     (divider_q),
            .active_o      (ch_active[i]),
            .tone_o        (ch_tone[i]),
            .wave_o        (ch_wave[i])
        );
    end

    // Walking from the top index down lets the lowest active channel
    // overwrite prio_bit last.
    always_comb begin
        xor_bit  = 1'b0;
        prio_bit = 1'b0;
        level_d  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            xor_bit = xor_bit ^ ch_wave[i];
            level_d = level_d + LVL_W'(ch_wave[i]);
            if (ch_active[i]) begin
                prio_bit = ch_tone[i];
            end
        end
        sound_d = (mode == MIX_PRIO) ? prio_bit : xor_bit;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            divider_q <= '0;
            sound_q   <= 1'b0;
            level_q   <= '0;
        end else begin
            divider_q <= divider_d;
            sound_q   <= sound_d;
            level_q   <= level_d;
        end
    end

    assign sound  = sound_q;
    assign level  = level_q;
    assign active = ch_active;

endmodule : multi_tone_sfx

// File: tb/tb_multi_tone_sfx.sv
// ---------------------------------------------------------------------------
// tb_multi_tone_sfx
// Directed scenarios plus randomized traffic against a countdown-style
// note model; expected {sound, level, active} per clk go through exp_q.
// ---------------------------------------------------------------------------
module tb_multi_tone_sfx;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 6;
    localparam int TAP_W  = 3;
    localparam int LEN_W  = 4;
    localparam int LVL_W  = 3;
    localparam int EXP_W  = 1 + LVL_W + NUM_CH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    logic                    line_pulse;
    logic                    frame_pulse;
    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH*TAP_W-1:0] tone_sel;
    logic [NUM_CH*LEN_W-1:0] length;
    logic                    mode;
    logic                    sound;
    logic [LVL_W-1:0]        level;
    logic [NUM_CH-1:0]       active;

    multi_tone_sfx #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .TAP_W  (TAP_W),
        .LEN_W  (LEN_W),
        .LVL_W  (LVL_W)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .line_pulse  (line_pulse),
        .frame_pulse (frame_pulse),
        .trig        (trig),
        .tone_sel    (tone_sel),
        .length      (length),
        .mode        (mode),
        .sound       (sound),
        .level       (level),
        .active      (active)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A playing note is tracked as "frame pulses left" rather than a
    // count-up; the note ends on the pulse that takes it to zero.
    logic [EXP_W-1:0] exp_q[$];
    bit m_play[NUM_CH];
    int m_left[NUM_CH];
    int m_tap[NUM_CH];
    int m_div;

    function automatic int sel_of(int i);
        int s;
        s = int'((tone_sel >> (i * TAP_W)) & ((1 << TAP_W) - 1));
        return (s > DIV_W - 1) ? DIV_W - 1 : s;
    endfunction

    function automatic int len_of(int i);
        return int'((length >> (i * LEN_W)) & ((1 << LEN_W) - 1));
    endfunction

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            exp_q.delete();
            m_div = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_play[i] = 0;
                m_left[i] = 0;
                m_tap[i]  = 0;
            end
        end else begin
            int  lvl;
            bit  xr;
            bit  pr;
            bit  found;
            bit  bitv;
            logic [NUM_CH-1:0] act_n;
            lvl = 0; xr = 0; pr = 0; found = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                bitv = m_play[i] && (((m_div >> m_tap[i]) & 1) == 1);
                lvl += int'(bitv);
                xr ^= bitv;
                if (m_play[i] && !found) begin
                    found = 1;
                    pr = ((m_div >> m_tap[i]) & 1) == 1;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!m_play[i]) begin
                    if (trig[i]) begin
                        m_play[i] = 1;
                        m_tap[i]  = sel_of(i);
                        m_left[i] = len_of(i) + 1;
                    end
                end else if (frame_pulse) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        if (trig[i]) begin
                            m_tap[i]  = sel_of(i);
                            m_left[i] = len_of(i) + 1;
                        end else begin
                            m_play[i] = 0;
                        end
                    end
                end else if (trig[i]) begin
                    m_tap[i]  = sel_of(i);
                    m_left[i] = len_of(i) + 1;
                end
                act_n[i] = m_play[i];
            end
            if (line_pulse) m_div = (m_div + 1) % (1 << DIV_W);
            exp_q.push_back({(mode ? pr : xr), LVL_W'(lvl), act_n});
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (nRst && exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            chk("sound",  32'(sound),  32'(e[EXP_W-1]));
            chk("level",  32'(level),  32'(e[NUM_CH +: LVL_W]));
            chk("active", 32'(active), 32'(e[NUM_CH-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit lp, input bit fp);
        line_pulse  = lp;
        frame_pulse = fp;
        tick();
        line_pulse  = 1'b0;
        frame_pulse = 1'b0;
    endtask

    task automatic set_ch(input int i, input int tap, input int len);
        tone_sel[i*TAP_W +: TAP_W] = TAP_W'(tap);
        length[i*LEN_W +: LEN_W]   = LEN_W'(len);
    endtask

    // Called just after a tick: reset lands between clock edges.
    task automatic rst_pulse();
        #2;
        nRst = 1'b0;
        #1;
        chk("rst_sound",  32'(sound),  32'd0);
        chk("rst_level",  32'(level),  32'd0);
        chk("rst_active", 32'(active), 32'd0);
        nRst = 1'b1;
        trig = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nRst = 1'b0; line_pulse = 0; frame_pulse = 0;
        trig = '0; tone_sel = '0; length = '0; mode = 1'b0;
        #3;
        chk("init_sound",  32'(sound),  32'd0);
        chk("init_level",  32'(level),  32'd0);
        chk("init_active", 32'(active), 32'd0);
        #5;
        nRst = 1'b1;

        // 1: divider runs a full wrap with nothing playing
        for (int k = 0; k < 66; k++) step(1, 0);
        chk("t1_sound", 32'(sound), 32'd0);
        chk("t1_level", 32'(level), 32'd0);

        // 2: ch0 tap 0, length 2
        rst_pulse();
        set_ch(0, 0, 2);
        trig = 4'b0001; tick(); trig = '0;
        chk("t2_start", 32'(active), 32'h1);
        step(1, 0);
        step(0, 0);
        chk("t2_tone_hi", 32'(sound), 32'd1);
        step(1, 0);
        step(0, 0);
        chk("t2_tone_lo", 32'(sound), 32'd0);
        step(0, 1); chk("t2_fp1", 32'(active), 32'h1);
        step(0, 1); chk("t2_fp2", 32'(active), 32'h1);
        step(0, 1); chk("t2_fp3", 32'(active), 32'h0);

        // 3: ch0 tap 1 (len 0), ch1 tap 2 (len 15), mixing modes
        rst_pulse();
        set_ch(0, 1, 0); set_ch(1, 2, 15); mode = 1'b0;
        trig = 4'b0011; tick(); trig = '0;
        for (int k = 0; k < 6; k++) step(1, 0);
        step(0, 0);
        chk("t3_xor", 32'(sound), 32'd0);
        chk("t3_lvl2", 32'(level), 32'd2);
        mode = 1'b1; step(0, 0);
        chk("t3_prio", 32'(sound), 32'd1);
        step(0, 1); step(0, 0);
        chk("t3_act", 32'(active), 32'h2);
        chk("t3_prio_ch1", 32'(sound), 32'd1);
        chk("t3_lvl1", 32'(level), 32'd1);
        mode = 1'b0;

        // 4: auto-repeat on ch2 with length 0
        rst_pulse();
        set_ch(2, 3, 0);
        trig = 4'b0100; tick();
        for (int k = 0; k < 3; k++) begin
            step(0, 1);
            chk("t4_repeat", 32'(active), 32'h4);
        end
        trig = '0; step(0, 0);
        chk("t4_hold", 32'(active), 32'h4);
        step(0, 1);
        chk("t4_idle", 32'(active), 32'h0);

        // 5: retrigger before end, start on a frame_pulse cycle
        rst_pulse();
        set_ch(0, 0, 2); set_ch(1, 0, 1);
        trig = 4'b0001; tick(); trig = '0;
        step(0, 1); step(0, 1);
        trig = 4'b0001; tick(); trig = '0;
        step(0, 1); step(0, 1);
        chk("t5_extended", 32'(active), 32'h1);
        step(0, 1);
        chk("t5_end", 32'(active), 32'h0);
        trig = 4'b0010; step(0, 1); trig = '0;
        chk("t5_fp_start", 32'(active), 32'h2);
        step(0, 1);
        chk("t5_fp_mid", 32'(active), 32'h2);
        step(0, 1);
        chk("t5_fp_end", 32'(active), 32'h0);

        // 6: tap clamp and reset mid-note
        rst_pulse();
        set_ch(0, 7, 15);
        trig = 4'b0001; tick(); trig = '0;
        for (int k = 0; k < 32; k++) step(1, 0);
        step(0, 0);
        chk("t6_clamp_hi", 32'(sound), 32'd1);
        chk("t6_clamp_lvl", 32'(level), 32'd1);
        for (int k = 0; k < 32; k++) step(1, 0);
        step(0, 0);
        chk("t6_clamp_lo", 32'(sound), 32'd0);
        rst_pulse();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 9) == 0) trig[i] = ~trig[i];
                if ($urandom_range(0, 19) == 0) set_ch(i, $urandom_range(0, 7), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
            if ($urandom_range(0, 699) == 0) rst_pulse();
        end
        trig = '0;
        for (int k = 0; k < 4; k++) step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multi_tone_sfx
